nes_dp_axis_packer: RTL
=======================

// Module: nes_dp_axis_packer
// PURPOSE
// Downstream of the NES DP raster generator, in the clk_pixel domain. Converts the raster
// stream (de/hsync/vsync + 36-bit video) into AXI4-Stream video for the DP TX subsystem:
// tuser marks start-of-frame, tlast marks end-of-line, and a FIFO absorbs tready backpressure.
// It flags overflow and raster-format errors and keeps a frame counter for bring-up.
// PARAMETERS
// DATA_W      36    pixel width, 3 x 12 bpc, passed through unmodified
// FIFO_AW     11    FIFO address bits; depth = 2**FIFO_AW = 2048 words
// H_ACTIVE    1920  active pixels per line
// V_ACTIVE    1080  active lines per frame
// PORTS
// clk_pixel      in   1         pixel clock; the only clock
// rst_pixel      in   1         synchronous, active-high reset
// de             in   1         data enable from raster generator
// hsync          in   1         positive polarity; used only for error checks
// vsync          in   1         positive polarity; rising edge = frame boundary
// video          in   DATA_W    pixel data, valid when de=1
// m_axis_tdata   out  DATA_W    pixel
// m_axis_tvalid  out  1         FIFO not empty
// m_axis_tready  in   1         sink accepts beat
// m_axis_tuser   out  1         1 on the first pixel of a frame (SOF)
// m_axis_tlast   out  1         1 on pixel H_ACTIVE-1 of each line (EOL)
// clr_status     in   1         clears the sticky flags; no effect on data path
// overflow       out  1         sticky: a pixel arrived while the FIFO was full
// fmt_err        out  1         sticky: line or frame length mismatch
// frame_count    out  16        frames fully written to the FIFO, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: tvalid=0, FIFO emptied, tuser/tlast=0, overflow=0, fmt_err=0, frame_count=0, state=SYNC.
//   Reset mid-frame discards all FIFO contents, and tvalid is 0 on the cycle after rst_pixel.
// - Input stage: de/video/vsync are registered once. vs_rise = vsync_q & ~vsync_qq.
// - Counters: x_cnt is 0..H_ACTIVE-1 and y_cnt is 0..V_ACTIVE-1; both are clog2-width.
// - FSM states:
//   SYNC:   discard pixels. On vs_rise go to FIRST.
//   FIRST:  wait for de. The first de pixel is written with tuser=1, x=y=0, and the FSM goes to ACTIVE.
//   ACTIVE: write every de pixel. tlast = (x_cnt==H_ACTIVE-1). After tlast, x_cnt wraps to 0
//           and y_cnt increments. The tlast pixel with y_cnt==V_ACTIVE-1 completes the frame:
//           frame_count++ and the FSM goes to SYNC.
// - Format errors (each sets fmt_err):
//   - de falls with x_cnt != 0 (short line). x_cnt is reset, y_cnt increments, and no tlast is forced.
//   - vs_rise while in ACTIVE (short frame). FSM goes straight to FIRST; frame_count does not increment.
//   - hsync_q=1 together with de_q=1.
// - FIFO: synchronous, first-word-fall-through, width DATA_W+2 ({tuser,tlast,data}).
//   - Write = pixel accepted by the FSM and FIFO not full.
//   - Read = tvalid & tready.
//   - Simultaneous read and write when full is allowed; the write succeeds.
//   - Full is judged before the same-cycle read. A write while full with no read sets overflow
//     and drops the pixel; the FSM then goes to SYNC and drops the rest of the frame.
//   - Already-queued beats still drain normally.
// - Latency: with the FIFO empty and tready=1, video at edge N appears on tdata with tvalid=1
//   after edge N+2 (input register, then FIFO write; FWFT has no read latency).
// - AXIS rules: tdata/tuser/tlast are stable while tvalid & ~tready. tvalid never drops without a handshake.
// - clr_status and a new error in the same cycle: the flag stays set (set wins).
// TESTING (sim with H_ACTIVE=8, V_ACTIVE=4, FIFO_AW=4)
// 1. Clean frame, tready=1: vsync pulse, then 4 lines x 8 de pixels (video = 0..31).
//    -> 32 beats in order; tuser only on beat 0; tlast on beats 7,15,23,31; frame_count=1; flags 0.
// 2. Latency: single de pixel 0xABC after SYNC->FIRST. -> tvalid=1 with tdata=0xABC exactly 2 edges later.
// 3. Backpressure: tready=0 for the whole frame. -> 16 beats stored; pixel 17 sets overflow; FSM goes to SYNC.
//    Then tready=1 -> exactly 16 beats drain. The next clean frame is intact with tuser on its first beat.
// 4. Short line: line 1 has de for 6 pixels. -> fmt_err=1; the next line starts at x=0;
//    no tlast on pixel 5 of line 1. clr_status pulse -> fmt_err=0.
// 5. Short frame: vs_rise after 2 lines. -> fmt_err=1; frame_count unchanged;
//    the next de pixel carries tuser=1.
// 6. Reset mid-frame with 5 beats queued and tready=0: -> tvalid=0 next cycle, frame_count=0,
//    and pixels are ignored until a vsync rise.

Source files
------------

// File: rtl/nes_dp_axis_packer_if.sv
// ---------------------------------------------------------------------------
// nes_dp_axis_packer_if
// AXI4-Stream video bundle between the NES DP packer and the DP TX subsystem.
//   tdata  : pixel word (3 x 12 bpc by default)
//   tvalid : source holds a beat
//   tready : sink accepts the beat on this edge
//   tuser  : start-of-frame marker on the first pixel of a frame
//   tlast  : end-of-line marker on the last active pixel of each line
// master = the packer (drives the beat), slave = the sink (drives tready).
// ---------------------------------------------------------------------------
interface nes_dp_axis_packer_if #(
    parameter int DATA_W = 36
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/nes_dp_axis_packer.sv
// ---------------------------------------------------------------------------
// nes_dp_axis_packer
// Turns the raster stream of the NES DP generator (de/hsync/vsync + pixel)
// into AXI4-Stream video. The first pixel of a frame carries tuser, the last
// active pixel of each line carries tlast, and a first-word-fall-through FIFO
// absorbs tready backpressure. Sticky flags report FIFO overflow and raster
// format errors; frame_count counts frames completely written to the FIFO.
//
// Ports
//   clk_pixel    : pixel clock, the only clock
//   rst_pixel    : synchronous active-high reset
//   de           : data enable, pixel valid when high
//   hsync        : positive polarity, only used to detect de/hsync overlap
//   vsync        : positive polarity, rising edge marks a frame boundary
//   video        : pixel data, passed through unmodified
//   m_axis       : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   clr_status   : clears overflow and fmt_err (a same-cycle error wins)
//   overflow     : sticky, a pixel was dropped because the FIFO was full
//   fmt_err      : sticky, short line, short frame or hsync during de
//   frame_count  : completed frames, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module nes_dp_axis_packer #(
    parameter int DATA_W   = 36,
    parameter int FIFO_AW  = 11,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic                  clk_pixel,
    input  logic                  rst_pixel,
    input  logic                  de,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [DATA_W-1:0]     video,
    nes_dp_axis_packer_if.master  m_axis,
    input  logic                  clr_status,
    output logic                  overflow,
    output logic                  fmt_err,
    output logic [15:0]           frame_count
);

    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = DATA_W + 2;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_FIRST,
        ST_ACTIVE
    } state_t;

    // Line index advance; wraps so that runaway short lines cannot walk off
    // the end of the frame.
    function automatic logic [YW-1:0] y_advance(input logic [YW-1:0] y);
        return (y == Y_LAST) ? '0 : y + YW'(1);
    endfunction

    // ---- stage p0: registered raster inputs --------------------------------
    logic              de_p0;
    logic              hsync_p0;
    logic              vsync_p0;
    logic              vsync_p1;
    logic [DATA_W-1:0] video_p0;
    logic              vs_rise;

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            de_p0    <= 1'b0;
            hsync_p0 <= 1'b0;
            vsync_p0 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            de_p0    <= de;
            hsync_p0 <= hsync;
            vsync_p0 <= vsync;
            vsync_p1 <= vsync_p0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        video_p0 <= video;
    end

    assign vs_rise = vsync_p0 & ~vsync_p1;

    // ---- stage p1: frame tracking FSM and FIFO write -----------------------
    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, base_x;
    logic [YW-1:0]   y_q, y_d, base_y;
    logic            accept;
    logic            pix_first;
    logic            pix_last;
    logic            pix_done;
    logic            short_err;
    logic            fmt_set;
    logic            ovf_set;
    logic            frame_done;
    logic            wr_en;
    logic            rd_en;

    logic [FW-1:0]      mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic [FW-1:0]      head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign rd_en      = ~fifo_empty & m_axis.tready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        accept    = 1'b0;
        pix_first = 1'b0;
        short_err = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (vs_rise) begin
                    state_d = ST_FIRST;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_FIRST: begin
                if (de_p0) begin
                    accept    = 1'b1;
                    pix_first = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise) begin
                    // Frame ended early: resynchronise on the new frame.
                    short_err = 1'b1;
                    state_d   = ST_FIRST;
                    x_d       = '0;
                    y_d       = '0;
                end else if (de_p0) begin
                    accept = 1'b1;
                end else if (x_q != '0) begin
                    // Line ended early: start the next line, no tlast forced.
                    short_err = 1'b1;
                    x_d       = '0;
                    y_d       = y_advance(y_q);
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // The SOF pixel always sits at the origin regardless of stale counters.
        base_x   = pix_first ? '0 : x_q;
        base_y   = pix_first ? '0 : y_q;
        pix_last = (base_x == X_LAST);
        pix_done = pix_last && (base_y == Y_LAST);

        // Fullness is judged before the same-cycle read, but a read frees the
        // slot in time for the write.
        wr_en      = accept && (!fifo_full || rd_en);
        ovf_set    = accept && fifo_full && !rd_en;
        frame_done = wr_en && pix_done;

        if (ovf_set) begin
            // A dropped pixel corrupts the frame; skip the rest of it.
            state_d = ST_SYNC;
        end else if (wr_en) begin
            if (pix_last) begin
                x_d     = '0;
                y_d     = y_advance(base_y);
                state_d = pix_done ? ST_SYNC : ST_ACTIVE;
            end else begin
                x_d     = base_x + XW'(1);
                y_d     = base_y;
                state_d = ST_ACTIVE;
            end
        end

        fmt_set = short_err | (hsync_p0 & de_p0);
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            state_q     <= ST_SYNC;
            x_q         <= '0;
            y_q         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            fmt_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
            end
            // Set has priority over clear.
            overflow <= ovf_set | (overflow & ~clr_status);
            fmt_err  <= fmt_set | (fmt_err & ~clr_status);
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {pix_first, pix_last, video_p0};
        end
    end

    // ---- stage p2: FWFT head drives the stream -----------------------------
    // Sideband bits are masked while empty so stale entries never show.
    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = head[DATA_W-1:0];
    assign m_axis.tlast  = ~fifo_empty & head[DATA_W];
    assign m_axis.tuser  = ~fifo_empty & head[DATA_W+1];

endmodule
